// File: rtl/spram_arbiter.sv
// spram_arbiter: two-port Wishbone classic arbiter in front of one spram, one access per two cycles.
// Define SPRAM_ARB_ROUND_ROBIN_EN for round-robin on contention; otherwise m0 has fixed priority.
module spram_arbiter #(
  parameter int size = 'h1000,
  parameter int addr_width = $clog2(size),
  parameter int data_width = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  m0_cyc,
  input  logic                  m0_stb,
  input  logic                  m0_we,
  input  logic [addr_width-1:0] m0_adr,
  input  logic [data_width-1:0] m0_dat_i,
  output logic [data_width-1:0] m0_dat_o,
  output logic                  m0_ack,
  input  logic                  m1_cyc,
  input  logic                  m1_stb,
  input  logic                  m1_we,
  input  logic [addr_width-1:0] m1_adr,
  input  logic [data_width-1:0] m1_dat_i,
  output logic [data_width-1:0] m1_dat_o,
  output logic                  m1_ack,
  output logic [addr_width-1:0] ram_address,
  output logic [data_width-1:0] ram_data,
  output logic                  ram_wren,
  output logic                  ram_cen,
  input  logic [data_width-1:0] ram_q
);
  typedef enum logic {IDLE, ACK} state_t;
  state_t state_q, state_d;
  logic grant_q, grant_d, last_q, last_d;
  logic req0, req1, tie, win;
  assign req0 = m0_cyc & m0_stb;
  assign req1 = m1_cyc & m1_stb;
`ifdef SPRAM_ARB_ROUND_ROBIN_EN
  assign tie = ~last_q;
`else
  assign tie = 1'b0;
`endif
  assign win = (req0 & req1) ? tie : req1;
  assign m0_dat_o = ram_q;
  assign m1_dat_o = ram_q;
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d = last_q;
    ram_cen = 1'b0;
    ram_wren = 1'b0;
    ram_address = m0_adr;
    ram_data = m0_dat_i;
    m0_ack = 1'b0;
    m1_ack = 1'b0;
    if (state_q == IDLE) begin
      if (req0 | req1) begin
        ram_cen = 1'b1;
        ram_wren = win ? m1_we : m0_we;
        ram_address = win ? m1_adr : m0_adr;
        ram_data = win ? m1_dat_i : m0_dat_i;
        grant_d = win;
        last_d = win;
        state_d = ACK;
      end
    end else begin
      // a requester that dropped cyc/stb here aborts: no ack, any write already landed
      m0_ack = ~grant_q & req0;
      m1_ack = grant_q & req1;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
    end
  end
endmodule

// File: tb/tb_spram_arbiter.sv
// tb_spram_arbiter: directed and randomized checks of spram_arbiter against a transaction-level model.
module tb_spram_arbiter;
`ifdef SPRAM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic m0_cyc = 0, m0_stb = 0, m0_we = 0, m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [11:0] m0_adr = 0, m1_adr = 0, ram_address;
  logic [15:0] m0_dat_i = 0, m1_dat_i = 0, m0_dat_o, m1_dat_o, ram_data, ram_q;
  logic m0_ack, m1_ack, ram_wren, ram_cen;
  logic [15:0] hmem [4096];
  int checks = 0, errors = 0;
  int pend = -1;
  bit last = 1'b1;
  logic [15:0] rmem [4096];
  bit rv [4096];
  bit pend_rd, pend_qv;
  logic [15:0] pend_q;

  spram_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_ack(m0_ack),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_ack(m1_ack),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_cen(ram_cen), .ram_q(ram_q)
  );

  always #5 clock = ~clock;

  // spram stand-in: synchronous read with read-during-write old data
  always @(posedge clock) begin
    if (ram_cen) begin
      if (ram_wren) hmem[ram_address] <= ram_data;
      ram_q <= hmem[ram_address];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit r0, input bit w0, input logic [11:0] a0, input logic [15:0] d0,
                       input bit r1, input bit w1, input logic [11:0] a1, input logic [15:0] d1);
    m0_cyc = r0; m0_stb = r0; m0_we = w0; m0_adr = a0; m0_dat_i = d0;
    m1_cyc = r1; m1_stb = r1; m1_we = w1; m1_adr = a1; m1_dat_i = d1;
  endtask

  // called at a negedge with inputs already applied; checks then advances one cycle
  task automatic step();
    bit r0, r1, we, e0, e1;
    int w;
    logic [11:0] a;
    logic [15:0] d;
    #1;
    r0 = m0_cyc & m0_stb;
    r1 = m1_cyc & m1_stb;
    if (pend >= 0) begin
      e0 = (pend == 0) && r0;
      e1 = (pend == 1) && r1;
      chk("ack_cen", ram_cen, 0);
      chk("ack_wren", ram_wren, 0);
      chk("m0_ack", m0_ack, e0);
      chk("m1_ack", m1_ack, e1);
      if ((e0 || e1) && pend_rd && pend_qv) begin
        chk("m0_dat_o", m0_dat_o, pend_q);
        chk("m1_dat_o", m1_dat_o, pend_q);
      end
      pend = -1;
    end else begin
      w = -1;
      if (r0 && r1) w = (RR && !last) ? 1 : 0;
      else if (r0) w = 0;
      else if (r1) w = 1;
      chk("idle_m0_ack", m0_ack, 0);
      chk("idle_m1_ack", m1_ack, 0);
      chk("idle_cen", ram_cen, w >= 0);
      if (w < 0) chk("idle_wren", ram_wren, 0);
      else begin
        we = w ? m1_we : m0_we;
        a = w ? m1_adr : m0_adr;
        d = w ? m1_dat_i : m0_dat_i;
        chk("wren", ram_wren, we);
        chk("address", ram_address, a);
        if (we) begin
          chk("wdata", ram_data, d);
          rmem[a] = d;
          rv[a] = 1'b1;
        end else begin
          pend_q = rmem[a];
          pend_qv = rv[a];
        end
        pend_rd = !we;
        pend = w;
        last = w[0];
      end
    end
    @(negedge clock);
  endtask

  function automatic logic [11:0] raddr();
    return ($urandom_range(0, 1) != 0) ? 12'($urandom_range(0, 7)) : 12'hFF8 + 12'($urandom_range(0, 7));
  endfunction

  initial begin
    // reset held with both strobes high: no acks, no writes
    drive(1, 0, 12'h000, 0, 1, 0, 12'h001, 0);
    @(negedge clock);
    #1;
    chk("rst_m0_ack", m0_ack, 0);
    chk("rst_m1_ack", m1_ack, 0);
    chk("rst_wren", ram_wren, 0);
    @(negedge clock);
    reset_n = 1'b1;
    step();
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    // single write then read of BEEF
    drive(1, 1, 12'h012, 16'hBEEF, 0, 0, 0, 0);
    step();
    step();
    drive(1, 0, 12'h012, 0, 0, 0, 0, 0);
    step();
    step();
    // contention: both hold read strobes for 8 cycles
    drive(1, 0, 12'h012, 0, 1, 0, 12'h012, 0);
    repeat (8) step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    // abort: m1 drops stb during its write ack cycle
    drive(0, 0, 0, 0, 1, 1, 12'h0FF, 16'h1234);
    step();
    m1_stb = 1'b0;
    step();
    drive(1, 0, 12'h0FF, 0, 0, 0, 0, 0);
    step();
    step();
    // address wrap: top and bottom words stay distinct
    drive(1, 1, 12'h000, 16'h0A0A, 0, 0, 0, 0);
    step();
    step();
    drive(0, 0, 0, 0, 1, 1, 12'hFFF, 16'h5AA5);
    step();
    step();
    drive(1, 0, 12'hFFF, 0, 0, 0, 0, 0);
    step();
    step();
    m0_adr = 12'h000;
    step();
    step();
    // async reset during ACK drops ack without a clock edge
    drive(1, 0, 12'h012, 0, 0, 0, 0, 0);
    step();
    #1;
    chk("pre_rst_m0_ack", m0_ack, 1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_m0_ack", m0_ack, 0);
    chk("async_rst_m1_ack", m1_ack, 0);
    pend = -1;
    last = 1'b1;
    @(negedge clock);
    reset_n = 1'b1;
    drive(1, 0, 12'h012, 0, 1, 0, 12'hFFF, 0);
    repeat (4) step();
    // randomized traffic, including aborts and back-to-back strobes
    repeat (600) begin
      drive($urandom_range(0, 2) != 0, $urandom_range(0, 1) != 0, raddr(), 16'($urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 1) != 0, raddr(), 16'($urandom));
      if ($urandom_range(0, 7) == 0) m0_cyc = ~m0_cyc;
      if ($urandom_range(0, 7) == 0) m1_stb = ~m1_stb;
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
